// File: rtl/tx_pkt_scheduler_if.sv
// rtl/tx_pkt_scheduler_if.sv - source-side and packetizer-side AXIS signals of the tx packet scheduler
interface tx_pkt_scheduler_if #(
  parameter int NREQ  = 2,
  parameter int BYTES = 1
);
  logic [NREQ*BYTES*8-1:0] S_tdata;
  logic [NREQ-1:0]         S_tvalid;
  logic [NREQ-1:0]         S_tready;
  logic [BYTES*8-1:0]      M_tdata;
  logic                    M_tvalid;
  logic                    M_tready;
  logic                    M_tlast;
  logic                    M_tuser;

  modport master (
    input  S_tdata, S_tvalid, M_tready,
    output S_tready, M_tdata, M_tvalid, M_tlast, M_tuser
  );

  modport slave (
    output S_tdata, S_tvalid, M_tready,
    input  S_tready, M_tdata, M_tvalid, M_tlast, M_tuser
  );
endinterface

// File: rtl/tx_pkt_scheduler.sv
// rtl/tx_pkt_scheduler.sv - round-robin scheduler sharing the MIX-mode tx packetizer between NREQ sources
module tx_pkt_scheduler #(
  parameter int BYTES      = 1,
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           MODE_CTRL,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   req_len,
  input  logic [NREQ-1:0]      req_bpsk,
  tx_pkt_scheduler_if.master   axis,
  output logic [15:0]          payload_length,
  input  logic                 pkt_sent,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 len_err
);
  localparam int PW = $clog2(NREQ);
  localparam int DW = BYTES * 8;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [3:0] MODE_MIX = 4'b0100;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_SENT, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            to_err_q, to_err_d;
  logic            len_err_q, len_err_d;
  logic [15:0]     plen_q, plen_d;
  logic            tuser_q, tuser_d;
  logic [15:0]     symbs_q, symbs_d;
  logic [15:0]     sym_cnt_q, sym_cnt_d;
  logic [15:0]     to_cnt_q, to_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            ps_q, ps_prev_q;

  logic            mix, found, xfer, m_valid, m_last;
  logic [PW-1:0]   win;
  logic [15:0]     win_len, win_symbs;
  logic            win_bpsk;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW:0] s);
    return (s >= (PW+1)'(NREQ)) ? PW'(s - (PW+1)'(NREQ)) : PW'(s);
  endfunction

  assign mix = (MODE_CTRL == MODE_MIX);

  // First asserted request at or after ptr, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[wrap_idx({1'b0, ptr_q} + (PW+1)'(k))]) begin
        found = 1'b1;
        win   = wrap_idx({1'b0, ptr_q} + (PW+1)'(k));
      end
    end
  end

  assign win_len   = req_len[win*16 +: 16];
  assign win_bpsk  = req_bpsk[win];
  assign win_symbs = win_bpsk ? win_len : (win_len >> 1);

  // Zero-latency data path so packetizer backpressure reaches the source directly.
  assign m_valid       = (state_q == STREAM) && axis.S_tvalid[gidx_q];
  assign m_last        = (state_q == STREAM) && (sym_cnt_q == symbs_q - 16'd1);
  assign xfer          = m_valid && axis.M_tready;
  assign axis.M_tdata  = axis.S_tdata[gidx_q*DW +: DW];
  assign axis.M_tvalid = m_valid;
  assign axis.M_tlast  = m_last;
  assign axis.M_tuser  = tuser_q;
  assign axis.S_tready = (state_q == STREAM) ? (NREQ'(axis.M_tready) << gidx_q) : '0;

  assign payload_length = plen_q;
  assign gnt            = gnt_q;
  assign done           = done_q;
  assign busy           = (state_q != IDLE);
  assign timeout_err    = to_err_q;
  assign len_err        = len_err_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    to_err_d  = 1'b0;
    len_err_d = 1'b0;
    plen_d    = plen_q;
    tuser_d   = tuser_q;
    symbs_d   = symbs_q;
    sym_cnt_d = sym_cnt_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (mix && found) begin
          plen_d    = win_len;
          tuser_d   = win_bpsk;
          symbs_d   = win_symbs;
          gidx_d    = win;
          ptr_d     = wrap_idx({1'b0, win} + (PW+1)'(1));
          if (win_symbs == 16'd0) begin
            done_d    = NREQ'(1) << win;
            len_err_d = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            gnt_d     = NREQ'(1) << win;
            sym_cnt_d = '0;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        if (!mix) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (xfer) begin
          sym_cnt_d = sym_cnt_q + 16'd1;
          if (m_last) begin
            to_cnt_d = '0;
            state_d  = WAIT_SENT;
          end
        end
      end
      WAIT_SENT: begin
        if (!mix) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (ps_q && !ps_prev_q) begin
          done_d    = gnt_q;
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
          to_err_d  = 1'b1;
          done_d    = gnt_q;
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      to_err_q  <= 1'b0;
      len_err_q <= 1'b0;
      plen_q    <= '0;
      tuser_q   <= 1'b1;
      symbs_q   <= '0;
      sym_cnt_q <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      ps_q      <= 1'b0;
      ps_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      to_err_q  <= to_err_d;
      len_err_q <= len_err_d;
      plen_q    <= plen_d;
      tuser_q   <= tuser_d;
      symbs_q   <= symbs_d;
      sym_cnt_q <= sym_cnt_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ps_q      <= pkt_sent;
      // Held high outside WAIT_SENT so a level already high on entry is not taken as an edge.
      ps_prev_q <= (state_q == WAIT_SENT) ? ps_q : 1'b1;
    end
  end
endmodule

// File: tb/tb_tx_pkt_scheduler.sv
// tb/tb_tx_pkt_scheduler.sv - scoreboard bench for tx_pkt_scheduler
module tb_tx_pkt_scheduler;
  localparam int NREQ    = 2;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  MODE_CTRL;
  logic [1:0]  req;
  logic [31:0] req_len;
  logic [1:0]  req_bpsk;
  logic [15:0] payload_length;
  logic        pkt_sent;
  logic [1:0]  gnt, done;
  logic        busy, timeout_err, len_err;

  tx_pkt_scheduler_if #(.NREQ(NREQ), .BYTES(1)) bus ();

  tx_pkt_scheduler #(.BYTES(1), .NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .MODE_CTRL(MODE_CTRL), .req(req), .req_len(req_len),
    .req_bpsk(req_bpsk), .axis(bus), .payload_length(payload_length), .pkt_sent(pkt_sent),
    .gnt(gnt), .done(done), .busy(busy), .timeout_err(timeout_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   src_idx [2] = '{0, 0};
  int   exp_idx [2] = '{0, 0};
  logic adv [2] = '{1'b0, 1'b0};
  int   xfer_cnt = 0, tlast_cnt = 0, last_tlast_edge = 0, done_cnt = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always_comb bus.S_tdata = {8'(64 + src_idx[1]), 8'(src_idx[0])};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) if (adv[i]) src_idx[i] = src_idx[i] + 1;
  end

  // Output monitor: every packetizer transfer is popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    adv[0] = 1'b0;
    adv[1] = 1'b0;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) adv[i] = bus.S_tvalid[i] & bus.S_tready[i];
      if (bus.M_tvalid && bus.M_tready) begin
        xfer_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: data %h last %b with no transfer required", bus.M_tdata, bus.M_tlast);
        end else begin
          e = sb.pop_front();
          if ({bus.M_tdata, bus.M_tlast, bus.M_tuser} !== {e.data, e.last, e.user}) begin
            errors++;
            $display("FAIL xfer_data: got data %h last %b user %b, required data %h last %b user %b",
                     bus.M_tdata, bus.M_tlast, bus.M_tuser, e.data, e.last, e.user);
          end
        end
        if (bus.M_tlast) begin
          tlast_cnt++;
          last_tlast_edge = cyc + 1;
        end
      end
      if (done != 2'b00) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(input int s, input logic [15:0] len, input logic bpsk);
    int   n;
    exp_t e;
    n = bpsk ? int'(len) : int'(len >> 1);
    for (int k = 0; k < n; k++) begin
      e.data = 8'(s * 64 + exp_idx[s] + k);
      e.last = (k == n - 1);
      e.user = bpsk;
      sb.push_back(e);
    end
    exp_idx[s] += n;
    req_len[s*16 +: 16] = len;
    req_bpsk[s] = bpsk;
    req[s] = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step(1);
      n++;
      if (gnt != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step(1);
      n++;
      if (done != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic wait_tlast(input int budget, output bit ok);
    int n = 0;
    int t0 = tlast_cnt;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step(1);
      n++;
      if (tlast_cnt != t0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if ({gnt, done, busy, timeout_err, len_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt %b done %b busy %b to %b len %b, required all 0", gnt, done, busy, timeout_err, len_err);
    end
    checks++;
    if (payload_length !== 16'd0 || bus.M_tuser !== 1'b1) begin
      errors++;
      $display("FAIL reset_hdr: payload_length %0d tuser %b, required 0 and 1", payload_length, bus.M_tuser);
    end
    checks++;
    if ({bus.M_tvalid, bus.M_tlast, bus.S_tready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_stream: tvalid %b tlast %b s_tready %b, required 0", bus.M_tvalid, bus.M_tlast, bus.S_tready);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_bpsk();
    bit ok;
    int x0, p, d;
    bus.S_tvalid[0] = 1'b1;
    x0 = xfer_cnt;
    request(0, 16'd5, 1'b1);
    wait_tlast(40, ok);
    checks++;
    if (!ok || xfer_cnt - x0 != 5) begin
      errors++;
      $display("FAIL bpsk_xfers: %0d transfers (tlast seen %b), required 5", xfer_cnt - x0, ok);
    end
    checks++;
    if (payload_length !== 16'd5 || bus.M_tuser !== 1'b1 || gnt !== 2'b01) begin
      errors++;
      $display("FAIL bpsk_hdr: len %0d tuser %b gnt %b, required 5 1 01", payload_length, bus.M_tuser, gnt);
    end
    step(50);
    pkt_sent = 1'b1;
    p = cyc;
    wait_done(10, ok);
    checks++;
    if (!ok || done !== 2'b01 || cyc != p + 2) begin
      errors++;
      $display("FAIL bpsk_done: done %b at edge %0d, required 01 at edge %0d", done, cyc, p + 2);
    end
    d = cyc;
    req[0] = 1'b0;
    pkt_sent = 1'b0;
    bus.S_tvalid[1] = 1'b1;
    request(1, 16'd9, 1'b0);
    wait_gnt(30, ok);
    checks++;
    if (!ok || gnt !== 2'b10 || cyc - d < GAP + 1) begin
      errors++;
      $display("FAIL gap_to_gnt: gnt %b after %0d edges, required 10 after at least %0d", gnt, cyc - d, GAP + 1);
    end
  endtask

  task automatic test_qpsk();
    bit ok;
    int x0 = xfer_cnt;
    checks++;
    if (payload_length !== 16'd9 || bus.M_tuser !== 1'b0) begin
      errors++;
      $display("FAIL qpsk_hdr: len %0d tuser %b, required 9 and 0", payload_length, bus.M_tuser);
    end
    wait_tlast(40, ok);
    checks++;
    if (!ok || xfer_cnt - x0 != 4) begin
      errors++;
      $display("FAIL qpsk_xfers: %0d transfers, required 4", xfer_cnt - x0);
    end
    step(3);
    pkt_sent = 1'b1;
    wait_done(10, ok);
    checks++;
    if (!ok || done !== 2'b10) begin
      errors++;
      $display("FAIL qpsk_done: done %b, required 10", done);
    end
    req[1] = 1'b0;
    pkt_sent = 1'b0;
    step(GAP + 2);
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] expg;
    request(0, 16'd2, 1'b1);
    request(1, 16'd2, 1'b1);
    request(0, 16'd2, 1'b1);
    request(1, 16'd2, 1'b1);
    for (int p = 0; p < 4; p++) begin
      expg = (p % 2 == 1) ? 2'b10 : 2'b01;
      wait_gnt(30, ok);
      checks++;
      if (!ok || gnt !== expg) begin
        errors++;
        $display("FAIL rr_gnt%0d: gnt %b, required %b", p, gnt, expg);
      end
      wait_tlast(20, ok);
      step(2);
      pkt_sent = 1'b1;
      wait_done(10, ok);
      checks++;
      if (!ok || done !== expg) begin
        errors++;
        $display("FAIL rr_done%0d: done %b, required %b", p, done, expg);
      end
      pkt_sent = 1'b0;
    end
    req = 2'b00;
    step(GAP + 2);
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    int x0 = xfer_cnt;
    int t0 = tlast_cnt;
    int n = 0;
    request(0, 16'd6, 1'b1);
    while (!ok && n < 60) begin
      bus.M_tready = ~bus.M_tready;
      step(1);
      n++;
      if (tlast_cnt != t0) ok = 1'b1;
    end
    checks++;
    if (!ok || xfer_cnt - x0 != 6) begin
      errors++;
      $display("FAIL bp_xfers: %0d transfers (tlast seen %b), required 6", xfer_cnt - x0, ok);
    end
    bus.M_tready = 1'b1;
    step(2);
    pkt_sent = 1'b1;
    wait_done(10, ok);
    checks++;
    if (!ok || done !== 2'b01) begin
      errors++;
      $display("FAIL bp_done: done %b, required 01", done);
    end
    req[0] = 1'b0;
    pkt_sent = 1'b0;
    step(GAP + 2);
  endtask

  task automatic test_len_err();
    bit ok;
    int x0 = xfer_cnt;
    request(1, 16'd1, 1'b0);
    wait_done(10, ok);
    checks++;
    if (!ok || done !== 2'b10 || len_err !== 1'b1 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL len_err: done %b len_err %b gnt %b, required 10 1 00", done, len_err, gnt);
    end
    req[1] = 1'b0;
    step(GAP + 2);
    checks++;
    if (xfer_cnt != x0) begin
      errors++;
      $display("FAIL len_err_xfers: %0d transfers, required 0", xfer_cnt - x0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t, n = 0;
    request(0, 16'd3, 1'b1);
    wait_tlast(20, ok);
    t = last_tlast_edge;
    ok = 1'b0;
    while (!ok && n < TIMEOUT + 20) begin
      step(1);
      n++;
      if (timeout_err === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok || cyc != t + TIMEOUT || done !== 2'b01) begin
      errors++;
      $display("FAIL timeout: err at edge %0d done %b, required edge %0d done 01", cyc, done, t + TIMEOUT);
    end
    req[0] = 1'b0;
    step(GAP + 2);
  endtask

  task automatic test_mode_abort();
    bit ok;
    int dc;
    bus.S_tvalid[1] = 1'b0;
    req_len[31:16] = 16'd8;
    req_bpsk[1] = 1'b1;
    req[1] = 1'b1;
    wait_gnt(20, ok);
    checks++;
    if (!ok || gnt !== 2'b10) begin
      errors++;
      $display("FAIL abort_gnt: gnt %b, required 10", gnt);
    end
    step(2);
    dc = done_cnt;
    MODE_CTRL = 4'b0001;
    step(1);
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: gnt %b busy %b, required 00 0", gnt, busy);
    end
    step(6);
    checks++;
    if (done_cnt != dc) begin
      errors++;
      $display("FAIL abort_done: %0d done pulses, required 0", done_cnt - dc);
    end
    req[1] = 1'b0;
    MODE_CTRL = 4'b0100;
    step(2);
  endtask

  task automatic test_reset_abort();
    bit ok;
    int dc;
    bus.S_tvalid[0] = 1'b1;
    request(0, 16'd2, 1'b1);
    wait_tlast(20, ok);
    step(3);
    checks++;
    if (busy !== 1'b1 || gnt !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre: busy %b gnt %b, required 1 01", busy, gnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, timeout_err, len_err, bus.M_tvalid, bus.M_tlast} !== 9'b0 ||
        payload_length !== 16'd0 || bus.M_tuser !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: gnt %b busy %b len %0d tuser %b, required 00 0 0 1", gnt, busy, payload_length, bus.M_tuser);
    end
    req = 2'b00;
    step(2);
    rst_n = 1'b1;
    dc = done_cnt;
    step(GAP + 4);
    checks++;
    if (done_cnt != dc || gnt !== 2'b00) begin
      errors++;
      $display("FAIL rst_after: %0d done pulses gnt %b, required 0 and 00", done_cnt - dc, gnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    MODE_CTRL = 4'b0100;
    req = 2'b00;
    req_len = '0;
    req_bpsk = 2'b00;
    pkt_sent = 1'b0;
    bus.S_tvalid = 2'b00;
    bus.M_tready = 1'b1;
    test_reset();
    test_single_bpsk();
    test_qpsk();
    test_round_robin();
    test_backpressure();
    test_len_err();
    test_timeout();
    test_mode_abort();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transfers outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
